// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - ALU condition-flag pipeline (pending + committed), bypass via FLAG_BYPASS_EN
module flag_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SetFlag,
    input  logic             Sub,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [WIDTH-1:0] Result,
    input  logic             Stall,
    input  logic             Flush,
    output logic [2:0]       Flag,
    output logic             FlagHazard,
    output logic             PendValid
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_PEND  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_pend;
    logic [2:0] r_comm;

    logic       w_z;
    logic       w_n;
    logic       w_v;
    logic       w_sign_a;
    logic       w_sign_b;
    logic       w_sign_r;
    logic [2:0] w_ex_flags;
    logic       w_ex_write;
    logic       w_pend_v;
    logic [2:0] w_flag;
    logic       w_hazard;

    assign w_sign_a   = OpA[WIDTH-1];
    assign w_sign_b   = OpB[WIDTH-1];
    assign w_sign_r   = Result[WIDTH-1];
    assign w_z        = (Result == '0);
    assign w_n        = w_sign_r;
    // Overflow: operand signs agree (add) or differ (sub) and the result sign flips away from OpA.
    assign w_v        = (Sub ? (w_sign_a != w_sign_b) : (w_sign_a == w_sign_b))
                        & (w_sign_r != w_sign_a);
    assign w_ex_flags = {w_z, w_v, w_n};
    assign w_ex_write = SetFlag & ~Flush;
    assign w_pend_v   = (r_state == S_PEND);

    always_comb begin
        w_state_next = r_state;
        if (!Stall) begin
            w_state_next = w_ex_write ? S_PEND : S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_pend  <= 3'b000;
            r_comm  <= 3'b000;
        end else if (!Stall) begin
            r_state <= w_state_next;
            r_pend  <= w_ex_flags;
            if (r_state == S_PEND) begin
                r_comm <= r_pend;
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    always_comb begin
        w_flag   = r_comm;
        w_hazard = 1'b0;
        if (w_ex_write) begin
            w_flag = w_ex_flags;
        end else if (w_pend_v) begin
            w_flag = r_pend;
        end
    end
`else
    always_comb begin
        w_flag   = r_comm;
        w_hazard = w_ex_write | w_pend_v;
    end
`endif

    // Reset masks the outputs in the same cycle, before the registers clear.
    always_comb begin
        Flag       = w_flag;
        FlagHazard = w_hazard;
        if (rst) begin
            Flag       = 3'b000;
            FlagHazard = 1'b0;
        end
    end

    assign PendValid = w_pend_v;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the ALU operand/result width.
REQ-002 Ports (name  direction  width  meaning) SHALL be as listed in REQ-003 to REQ-012; there SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 SetFlag  in  1  the EX-stage instruction updates flags.
REQ-006 Sub  in  1  EX operation: 1 = OpA-OpB, 0 = OpA+OpB.
REQ-007 OpA, OpB  in  WIDTH  EX-stage ALU operands.
REQ-008 Result  in  WIDTH  EX-stage ALU result.
REQ-009 Stall  in  1  hold all flag state this cycle.
REQ-010 Flush  in  1  kill the EX-stage instruction; no flag write.
REQ-011 Flag  out  3  {Z,V,N} to the branch unit: bit2=Z, bit1=V, bit0=N.
REQ-012 FlagHazard  out  1  flags are not yet valid for a branch; ID must stall. PendValid  out  1  pending-register valid.

Function
REQ-013 EX flags SHALL be combinational: Z = (Result==0); N = Result[WIDTH-1]; V(add) = (OpA[msb]==OpB[msb]) & (Result[msb]!=OpA[msb]); V(sub) = (OpA[msb]!=OpB[msb]) & (Result[msb]!=OpA[msb]).
REQ-014 ExWrite SHALL equal SetFlag & ~Flush.
REQ-015 State SHALL be a pending register Pend[2:0] with valid bit PendV (state EMPTY when PendV=0, PEND when PendV=1) and a committed register Comm[2:0].
REQ-016 On an edge with rst=0 and Stall=0: Pend <= EX flags and PendV <= ExWrite; if PendV=1, Comm <= Pend.
REQ-017 EMPTY->PEND on ExWrite; PEND->PEND on ExWrite (Comm takes the old Pend in the same edge); PEND->EMPTY on ~ExWrite after committing Pend.
REQ-018 On an edge with Stall=1 and rst=0, Pend, PendV and Comm SHALL hold; a Flush during Stall SHALL only mask the combinational bypass.
REQ-019 Back-to-back flag writers SHALL lose no update; Comm SHALL always reflect program order.
REQ-020 PendValid SHALL equal PendV.

Reset
REQ-021 When rst=1 at an edge: Pend=000, PendV=0, Comm=000; rst SHALL take priority over Stall and Flush.
REQ-022 While rst=1, Flag SHALL be forced to 000 and FlagHazard to 0; a reset with PendV=1 SHALL discard the pending flags.

Configuration
REQ-023 Macro FLAG_BYPASS_EN defined: Flag = ExWrite ? EX flags : (PendV ? Pend : Comm); FlagHazard tied to 0; latency 0 cycles.
REQ-024 FLAG_BYPASS_EN undefined: Flag = Comm; FlagHazard = ExWrite | PendV; a write in cycle t becomes visible on Flag in cycle t+2 (plus any stall cycles).
REQ-025 The state update rules SHALL be identical in both builds.

Verification
REQ-026 Bypass build, WIDTH=16: Sub=0, OpA=7FFF, OpB=0001, Result=8000, SetFlag=1 at cycle t -> Flag=011 at t, PendV=1 at t+1, Comm=011 at t+2.
REQ-027 Sub=1, OpA=0005, OpB=0005, Result=0000, SetFlag=1 -> Flag=100; a downstream branch with Cond=EQ is taken.
REQ-028 Flush=1 with SetFlag=1, prior Comm=001 -> PendV stays 0, Flag stays 001.
REQ-029 PendV=1, Pend=100, Stall=1 for 3 cycles -> Pend and Comm unchanged for those cycles; Comm=100 on the first edge after Stall falls.
REQ-030 Non-bypass build, SetFlag=1 at t only -> FlagHazard=1 at t and t+1, 0 at t+2; Flag changes at t+2.
REQ-031 rst=1 while PendV=1, Pend=010 -> after the edge: Flag=000, PendV=0, FlagHazard=0.
